// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: run / data-wait / halt FSM driving the
// PC and pipeline-latch enables, plus sticky halt flag and stall/flush counters.
module pipe_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        hazard,
  input  logic        branch,
  input  logic        jump,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        dstall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    dstall     = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    case (state_q)
      RUN, DWAIT: begin
        dstall     = (mem_dREN | mem_dWEN) & ~dhit;
        pc_en      = ihit & ~hazard & ~dstall;
        ifid_en    = ihit & ~hazard & ~dstall;
        // A held ID instruction is re-evaluated next cycle, so no flush under hazard.
        ifid_flush = (branch | jump) & ihit & ~hazard & ~dstall;
        idex_en    = ~dstall;
        idex_flush = (hazard | ~ihit) & ~dstall;
        exmem_en   = ~dstall;
        memwb_en   = ~dstall;
        if (wb_halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (dstall) begin
          state_d = DWAIT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALT) && !pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    flush_cnt_d = flush_cnt_q + {7'd0, ifid_flush};
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts outputs per
// cycle, expectations are queued at drive time and popped when sampled.
module tb_pipe_ctrl;

  typedef struct packed {
    logic ihit, dhit, dren, dwen, hazard, branch, jump, wb_halt;
  } in_t;

  typedef struct packed {
    logic        pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb, halted;
    logic [15:0] stall;
    logic [7:0]  flush;
  } obs_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
  logic        hazard = 1'b0, branch = 1'b0, jump = 1'b0, wb_halt = 1'b0;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  int checks = 0;
  int failures = 0;
  obs_t sb_q[$];

  int          m_state;
  logic        m_halted;
  logic [15:0] m_stall;
  logic [7:0]  m_flush;

  pipe_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .hazard(hazard),
    .branch(branch), .jump(jump), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic in_t mk(logic ih, logic dh, logic rd, logic wr,
                             logic hz, logic br, logic jp, logic wh);
    in_t s;
    s = {ih, dh, rd, wr, hz, br, jp, wh};
    return s;
  endfunction

  function automatic obs_t predict(in_t s);
    obs_t e;
    logic ds;
    e = '0;
    e.halted = m_halted;
    e.stall  = m_stall;
    e.flush  = m_flush;
    if (m_state != 2) begin
      ds        = (s.dren | s.dwen) & ~s.dhit;
      e.pc      = s.ihit & ~s.hazard & ~ds;
      e.ifid_en = s.ihit & ~s.hazard & ~ds;
      e.ifid_fl = (s.branch | s.jump) & s.ihit & ~s.hazard & ~ds;
      e.idex_en = ~ds;
      e.idex_fl = (s.hazard | ~s.ihit) & ~ds;
      e.exmem   = ~ds;
      e.memwb   = ~ds;
    end
    return e;
  endfunction

  task automatic model_edge(input in_t s, input obs_t e);
    if (m_state != 2 && !e.pc && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (e.ifid_fl) m_flush = m_flush + 8'd1;
    if (m_state != 2) begin
      if (s.wb_halt) begin
        m_state  = 2;
        m_halted = 1'b1;
      end else if ((s.dren | s.dwen) & ~s.dhit) begin
        m_state = 1;
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_halted = 1'b0;
    m_stall  = 16'd0;
    m_flush  = 8'd0;
    sb_q.delete();
  endtask

  task automatic drive(input in_t s);
    ihit = s.ihit; dhit = s.dhit; mem_dREN = s.dren; mem_dWEN = s.dwen;
    hazard = s.hazard; branch = s.branch; jump = s.jump; wb_halt = s.wb_halt;
  endtask

  // One clock: drive at negedge, queue the prediction, sample 1 unit later.
  task automatic step(input in_t s, output obs_t o);
    obs_t e;
    @(negedge CLK);
    drive(s);
    e = predict(s);
    sb_q.push_back(e);
    model_edge(s, e);
    #1;
    o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
         halted, stall_cnt, flush_cnt};
  endtask

  task automatic do_reset();
    @(negedge CLK);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0));
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checks++;
    if ({halted, stall_cnt, flush_cnt} !== 25'd0) begin
      failures++;
      $display("FAIL reset_regs got=%h exp=%h", {halted, stall_cnt, flush_cnt}, 25'd0);
    end
    checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en} !== 7'b0001111) begin
      failures++;
      $display("FAIL reset_run_eqns got=%b exp=%b",
               {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, 7'b0001111);
    end
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_no_count got=%h exp=%h", stall_cnt, 16'd0);
    end
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0));
    nRST = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_run_idle();
    obs_t o, e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(mk(1, 0, 0, 0, 0, 0, 0, 0), o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL run_idle cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    checks++;
    if ({o.pc, o.ifid_en, o.ifid_fl, o.idex_en, o.idex_fl, o.exmem, o.memwb, o.stall} !== {7'b1101011, 16'd0}) begin
      failures++;
      $display("FAIL run_idle_final got=%h exp=%h",
               {o.pc, o.ifid_en, o.ifid_fl, o.idex_en, o.idex_fl, o.exmem, o.memwb, o.stall},
               {7'b1101011, 16'd0});
    end
    $display("test_run_idle done");
  endtask

  task automatic test_dwait();
    obs_t o, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(mk(1, (i == 3), 1, 0, 0, 0, 0, 0), o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL dwait cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i < 3) begin
        checks++;
        if ({o.pc, o.ifid_en, o.ifid_fl, o.idex_en, o.idex_fl, o.exmem, o.memwb} !== 7'd0) begin
          failures++;
          $display("FAIL dwait_enables cyc=%0d got=%b exp=%b", i,
                   {o.pc, o.ifid_en, o.ifid_fl, o.idex_en, o.idex_fl, o.exmem, o.memwb}, 7'd0);
        end
      end
    end
    checks++;
    if ({o.pc, o.ifid_en, o.ifid_fl, o.idex_en, o.idex_fl, o.exmem, o.memwb, o.stall} !== {7'b1101011, 16'd3}) begin
      failures++;
      $display("FAIL dwait_dhit got=%h exp=%h",
               {o.pc, o.ifid_en, o.ifid_fl, o.idex_en, o.idex_fl, o.exmem, o.memwb, o.stall},
               {7'b1101011, 16'd3});
    end
    step(mk(1, 1, 0, 0, 0, 0, 0, 0), o);
    e = sb_q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL dhit_noop got=%h exp=%h", o, e);
    end
    $display("test_dwait done");
  endtask

  task automatic test_hazard_branch();
    obs_t o, e;
    in_t seq [4];
    do_reset();
    seq[0] = mk(1, 0, 0, 0, 1, 1, 0, 0);
    seq[1] = mk(1, 0, 0, 0, 1, 0, 1, 0);
    seq[2] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    seq[3] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(seq[i], o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL hazard_branch cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i == 0) begin
        checks++;
        if ({o.pc, o.ifid_en, o.ifid_fl, o.idex_fl} !== 4'b0001) begin
          failures++;
          $display("FAIL hazard_prio got=%b exp=%b", {o.pc, o.ifid_en, o.ifid_fl, o.idex_fl}, 4'b0001);
        end
      end
    end
    checks++;
    if (o.flush !== 8'd0) begin
      failures++;
      $display("FAIL hazard_flush_cnt got=%h exp=%h", o.flush, 8'd0);
    end
    $display("test_hazard_branch done");
  endtask

  task automatic test_flush_wrap();
    obs_t o, e;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      step((i < 256) ? mk(1, 0, 0, 0, 0, i[0], ~i[0], 0) : mk(1, 0, 0, 0, 0, 0, 0, 0), o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL flush_wrap cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i == 1) begin
        checks++;
        if (o.flush !== 8'd1) begin
          failures++;
          $display("FAIL flush_inc got=%h exp=%h", o.flush, 8'd1);
        end
      end
    end
    checks++;
    if ({o.flush, o.stall} !== 24'd0) begin
      failures++;
      $display("FAIL flush_wrap_zero got=%h exp=%h", {o.flush, o.stall}, 24'd0);
    end
    $display("test_flush_wrap done");
  endtask

  task automatic test_halt();
    obs_t o, e;
    in_t seq [6];
    do_reset();
    seq[0] = mk(1, 0, 1, 0, 0, 0, 0, 0);
    seq[1] = mk(1, 0, 1, 0, 0, 0, 0, 1);
    seq[2] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    seq[4] = mk(1, 0, 1, 1, 0, 0, 0, 0);
    seq[5] = mk(1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(seq[i], o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i >= 2) begin
        checks++;
        if (o !== {8'b0000_0001, 16'd2, 8'd0}) begin
          failures++;
          $display("FAIL halt_frozen cyc=%0d got=%h exp=%h", i, o, {8'b0000_0001, 16'd2, 8'd0});
        end
      end
    end
    @(negedge CLK);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0));
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({halted, stall_cnt, flush_cnt, pc_en, ifid_en} !== {25'd0, 2'b11}) begin
      failures++;
      $display("FAIL halt_async_reset got=%h exp=%h",
               {halted, stall_cnt, flush_cnt, pc_en, ifid_en}, {25'd0, 2'b11});
    end
    #1 nRST = 1'b1;
    model_reset();
    $display("test_halt done");
  endtask

  task automatic test_random();
    obs_t o, e;
    in_t s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = in_t'($urandom_range(0, 255));
      s.ihit    = ($urandom_range(0, 3) != 0);
      s.wb_halt = (i > 350) && ($urandom_range(0, 15) == 0);
      step(s, o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random cyc=%0d in=%h got=%h exp=%h", i, s, o, e);
      end
    end
    $display("test_random done");
  endtask

  task automatic test_saturate();
    obs_t o, e;
    do_reset();
    for (int i = 0; i < 70005; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0), o);
      e = sb_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL saturate cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    checks++;
    if (o.stall !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate_final got=%h exp=%h", o.stall, 16'hFFFF);
    end
    $display("test_saturate done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_idle();
    test_dwait();
    test_hazard_branch();
    test_flush_wrap();
    test_halt();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
